// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline stage register with a one-entry skid buffer, flush and bubble counter.
// Latency: 1 cycle from an input capture to the output. Sustains 1 entry/cycle.
// Backpressure: a stall absorbs one extra entry in the skid buffer; in_ready drops only while the skid buffer is full.
module pipe_stage_skid #(
  parameter int DATA_W  = 64,
  parameter int CTRL_W  = 16,
  parameter int SFX_W   = 4,
  parameter int INSTR_W = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0800
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [CTRL_W-1:0]  in_ctrl,
  input  logic [SFX_W-1:0]   in_sfx,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic [SFX_W-1:0]   out_sfx,
  output logic [INSTR_W-1:0] out_instr,
  output logic [15:0]        bubble_cnt
);

  localparam int ENTRY_W = DATA_W + CTRL_W + SFX_W + INSTR_W;

  // Occupancy encoding: EMPTY = nothing held, FULL = head only, SKID = head plus skid entry.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [ENTRY_W-1:0] main_q, main_d;
  logic [ENTRY_W-1:0] skid_q, skid_d;
  logic [15:0]        bubble_q, bubble_d;

  logic               in_fire, out_fire;
  logic [ENTRY_W-1:0] in_entry;

  logic [DATA_W-1:0]  main_data;
  logic [CTRL_W-1:0]  main_ctrl;
  logic [SFX_W-1:0]   main_sfx;
  logic [INSTR_W-1:0] main_instr;

  assign in_entry = {in_data, in_ctrl, in_sfx, in_instr};
  assign {main_data, main_ctrl, main_sfx, main_instr} = main_q;

  // in_ready comes straight from the state register so it never depends on out_ready.
  assign in_ready  = (state_q != ST_SKID);
  assign out_valid = (state_q != ST_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Data/ctrl keep showing the last head contents; side effects and instruction are masked into a bubble.
  assign out_data   = main_data;
  assign out_ctrl   = main_ctrl;
  assign out_sfx    = out_valid ? main_sfx : '0;
  assign out_instr  = out_valid ? main_instr : NOP_INSTR;
  assign bubble_cnt = bubble_q;

  // Next-state for occupancy and storage; flush empties the stage without touching stored contents.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_d  = in_entry;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_d = in_entry;
          end else if (in_fire) begin
            // Head is stalled: park the new entry behind it so order is preserved.
            skid_d  = in_entry;
            state_d = ST_SKID;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Saturating count of cycles where downstream was ready but had nothing to take.
  always_comb begin
    bubble_d = bubble_q;
    if (out_ready && !out_valid && (bubble_q != 16'hFFFF)) begin
      bubble_d = bubble_q + 16'd1;
    end
  end

  // State update; reset wins over flush and any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      main_q   <= '0;
      skid_q   <= '0;
      bubble_q <= '0;
    end else begin
      state_q  <= state_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
      bubble_q <= bubble_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed test bench for pipe_stage_skid: reset, streaming, skid stall, flush, reset mid-transfer, counter saturation.
// Inputs driven 1 time unit after each rising edge; outputs sampled at the same point.
// All expected values are hand-computed constants in the stimulus.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [15:0] in_ctrl;
  logic [3:0]  in_sfx;
  logic [15:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [15:0] out_ctrl;
  logic [3:0]  out_sfx;
  logic [15:0] out_instr;
  logic [15:0] bubble_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pipe_stage_skid dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .in_sfx    (in_sfx),
    .in_instr  (in_instr),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .out_sfx   (out_sfx),
    .out_instr (out_instr),
    .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] instr, input logic [3:0] sfx,
                       input logic [63:0] data, input logic [15:0] ctrl);
    in_valid = v;
    in_instr = instr;
    in_sfx   = sfx;
    in_data  = data;
    in_ctrl  = ctrl;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
    chk({tag, "_out_data"},  out_data,       64'd0);
    chk({tag, "_out_ctrl"},  64'(out_ctrl),  64'd0);
    chk({tag, "_out_sfx"},   64'(out_sfx),   64'd0);
    chk({tag, "_out_instr"}, 64'(out_instr), 64'h0800);
    chk({tag, "_bubble"},    64'(bubble_cnt), 64'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 64'h0, 16'h0);

    // Reset, then idle with downstream ready.
    tick(); tick();
    rst = 1'b0;
    out_ready = 1'b1;
    chk_reset_outputs("rst");
    repeat (5) tick();
    chk("idle_bubble",    64'(bubble_cnt), 64'd5);
    chk("idle_out_valid", 64'(out_valid),  64'd0);
    chk("idle_out_instr", 64'(out_instr),  64'h0800);
    chk("idle_out_sfx",   64'(out_sfx),    64'd0);
    chk("idle_in_ready",  64'(in_ready),   64'd1);

    // Back-to-back stream 1001..1008: each shows up one cycle after capture.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'h1001 + 16'(i), 4'(i), 64'hD000_0000_0000_0000 + 64'(i), 16'h0C00 + 16'(i));
      tick();
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_instr", 64'(out_instr), 64'h1001 + 64'(i));
      chk("stream_data",  out_data,       64'hD000_0000_0000_0000 + 64'(i));
      chk("stream_ctrl",  64'(out_ctrl),  64'h0C00 + 64'(i));
      chk("stream_sfx",   64'(out_sfx),   64'(i));
      chk("stream_rdy",   64'(in_ready),  64'd1);
    end
    drive(1'b0, 16'h0, 4'h0, 64'h0, 16'h0);
    tick();
    chk("stream_drain_valid", 64'(out_valid), 64'd0);
    chk("stream_bubble",      64'(bubble_cnt), 64'd6);

    // Stall downstream: A001 goes to head, A002 to skid, in_ready drops.
    out_ready = 1'b0;
    drive(1'b1, 16'hA001, 4'h3, 64'hAAAA_0001, 16'h0A01);
    tick();
    chk("skid_a1_instr", 64'(out_instr), 64'hA001);
    chk("skid_a1_rdy",   64'(in_ready),  64'd1);
    drive(1'b1, 16'hA002, 4'h5, 64'hAAAA_0002, 16'h0A02);
    tick();
    chk("skid_full_rdy",   64'(in_ready),  64'd0);
    chk("skid_full_instr", 64'(out_instr), 64'hA001);
    chk("skid_full_valid", 64'(out_valid), 64'd1);
    // Offer an entry that must be refused while the skid slot is occupied.
    drive(1'b1, 16'hA0FF, 4'hF, 64'hFFFF, 16'hFFFF);
    tick();
    chk("skid_hold_instr", 64'(out_instr), 64'hA001);
    chk("skid_hold_data",  out_data,       64'hAAAA_0001);
    chk("skid_hold_sfx",   64'(out_sfx),   64'h3);
    chk("skid_hold_rdy",   64'(in_ready),  64'd0);
    drive(1'b0, 16'h0, 4'h0, 64'h0, 16'h0);
    out_ready = 1'b1;
    tick();
    chk("skid_pop1_instr", 64'(out_instr), 64'hA002);
    chk("skid_pop1_sfx",   64'(out_sfx),   64'h5);
    chk("skid_pop1_rdy",   64'(in_ready),  64'd1);
    tick();
    chk("skid_pop2_valid", 64'(out_valid), 64'd0);
    chk("skid_bubble",     64'(bubble_cnt), 64'd6);

    // Flush while in SKID with a competing input: everything is discarded.
    out_ready = 1'b0;
    drive(1'b1, 16'hC001, 4'h1, 64'hCCCC_0001, 16'h0C01);
    tick();
    drive(1'b1, 16'hC002, 4'h2, 64'hCCCC_0002, 16'h0C02);
    tick();
    chk("flush_pre_rdy", 64'(in_ready), 64'd0);
    drive(1'b1, 16'hB000, 4'hF, 64'hBBBB_0000, 16'h0B00);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 64'h0, 16'h0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_sfx",   64'(out_sfx),   64'd0);
    chk("flush_instr", 64'(out_instr), 64'h0800);
    chk("flush_rdy",   64'(in_ready),  64'd1);
    chk("flush_data",  out_data,       64'hCCCC_0001);
    out_ready = 1'b1;
    tick();
    chk("flush_after_valid", 64'(out_valid), 64'd0);
    chk("flush_after_instr", 64'(out_instr), 64'h0800);
    tick();
    chk("flush_bubble", 64'(bubble_cnt), 64'd8);

    // Reset while FULL with both in_fire and out_fire active.
    drive(1'b1, 16'hD001, 4'h7, 64'hDDDD_0001, 16'h0D01);
    tick();
    chk("rstmid_pre_valid", 64'(out_valid), 64'd1);
    drive(1'b1, 16'hD002, 4'h7, 64'hDDDD_0002, 16'h0D02);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 16'h0, 4'h0, 64'h0, 16'h0);
    out_ready = 1'b0;
    chk_reset_outputs("rstmid");

    // Bubble counter saturation, then cleared only by reset.
    out_ready = 1'b1;
    repeat (65534) tick();
    chk("sat_fffe", 64'(bubble_cnt), 64'hFFFE);
    tick();
    chk("sat_ffff", 64'(bubble_cnt), 64'hFFFF);
    repeat (4465) tick();
    chk("sat_hold", 64'(bubble_cnt), 64'hFFFF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("sat_flush_keep", 64'(bubble_cnt), 64'hFFFF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("sat_rst_clear", 64'(bubble_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
